vectored_int_ctrl: RTL



---
 rtl/vectored_int_ctrl_if.sv | 31 +++
 rtl/vectored_int_ctrl.sv | 77 +++++++
 2 files changed

// File: rtl/vectored_int_ctrl_if.sv
// vectored_int_ctrl_if: peripheral/core side signals of the vectored interrupt controller (int_mask exists only with VINT_MASK_EN)
interface vectored_int_ctrl_if;
  logic        done1;
  logic        done2;
  logic        done3;
  logic        done4;
  logic        int_ack;
  logic        eoi;
  logic        interrupt;
  logic [31:0] int_addr;
  logic [1:0]  irq_id;
  logic [3:0]  pending;
  logic        in_service;
`ifdef VINT_MASK_EN
  logic [3:0]  int_mask;
`endif
  modport master (
    output done1, done2, done3, done4, int_ack, eoi,
    input  interrupt, int_addr, irq_id, pending, in_service
`ifdef VINT_MASK_EN
    , output int_mask
`endif
  );
  modport slave (
    input  done1, done2, done3, done4, int_ack, eoi,
    output interrupt, int_addr, irq_id, pending, in_service
`ifdef VINT_MASK_EN
    , input int_mask
`endif
  );
endinterface

// File: rtl/vectored_int_ctrl.sv
// vectored_int_ctrl: edge-detects four done lines into pending bits and issues prioritised vectored requests (VINT_MASK_EN adds int_mask)
module vectored_int_ctrl #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input logic            clk,
  input logic            reset,
  vectored_int_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  done_q, pending_q, pending_d, done_now, eligible, clr;
  logic [1:0]  irq_id_q, irq_id_d, sel;
  logic [31:0] int_addr_q, int_addr_d;
  logic        interrupt_q, interrupt_d, in_service_q, in_service_d;
  assign done_now = {bus.done4, bus.done3, bus.done2, bus.done1};
`ifdef VINT_MASK_EN
  assign eligible = pending_q & ~bus.int_mask;
`else
  assign eligible = pending_q;
`endif
  assign sel = eligible[0] ? 2'd0 : eligible[1] ? 2'd1 : eligible[2] ? 2'd2 : 2'd3;
  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    int_addr_d   = int_addr_q;
    interrupt_d  = interrupt_q;
    in_service_d = in_service_q;
    clr          = '0;
    case (state_q)
      IDLE: if (|eligible) begin
        state_d     = REQ;
        irq_id_d    = sel;
        int_addr_d  = VEC_BASE + 32'(sel) * VEC_STRIDE;
        interrupt_d = 1'b1;
      end
      REQ: if (bus.int_ack) begin
        state_d      = SERVICE;
        interrupt_d  = 1'b0;
        in_service_d = 1'b1;
        clr          = 4'b0001 << irq_id_q;
      end
      SERVICE: if (bus.eoi) begin
        state_d      = IDLE;
        in_service_d = 1'b0;
        int_addr_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // a rise on the acceptance edge re-arms the bit: set wins over clear
    pending_d = (pending_q & ~clr) | (done_now & ~done_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      done_q       <= '0;
      pending_q    <= '0;
      irq_id_q     <= '0;
      int_addr_q   <= '0;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_now;
      pending_q    <= pending_d;
      irq_id_q     <= irq_id_d;
      int_addr_q   <= int_addr_d;
      interrupt_q  <= interrupt_d;
      in_service_q <= in_service_d;
    end
  end
  assign bus.interrupt  = interrupt_q;
  assign bus.int_addr   = int_addr_q;
  assign bus.irq_id     = irq_id_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
endmodule
